// File: rtl/irq_ctrl.sv
// Interrupt controller: per-line edge/level detection into a write-1-to-clear
// pending register, masked onto CP0 hardware-interrupt lines, with a priority ID.
module irq_ctrl #(
   parameter int               N_SRC    = 6,
   parameter logic [N_SRC-1:0] RST_MASK = '0,
   parameter logic [N_SRC-1:0] RST_MODE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       addr,
   input  logic             we,
   input  logic [31:0]      din,
   output logic [31:0]      dout,
   input  logic [N_SRC-1:0] src,
   output logic [N_SRC-1:0] hw_int,
   output logic             irq_out
);

   localparam logic [1:0] A_PEND = 2'd0;
   localparam logic [1:0] A_MASK = 2'd1;
   localparam logic [1:0] A_MODE = 2'd2;
   localparam logic [1:0] A_ID   = 2'd3;

   logic [N_SRC-1:0] pend;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] mode;
   logic [N_SRC-1:0] src_q;

   logic [N_SRC-1:0] set_vec;
   logic [N_SRC-1:0] clr_vec;
   logic [N_SRC-1:0] wr_data;
   logic [31:0]      id;
   logic             unused_din;

   assign wr_data    = din[N_SRC-1:0];
   assign unused_din = ^din[31:N_SRC];

   // Edge-mode bits fire on a rising transition; level-mode bits fire while high.
   assign set_vec = (mode & src & ~src_q) | (~mode & src);
   assign clr_vec = (we && addr == A_PEND) ? wr_data : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend  <= '0;
         mask  <= RST_MASK;
         mode  <= RST_MODE;
         src_q <= '0;
      end else begin
         src_q <= src;
         // A set in the same cycle as a clear keeps the bit asserted.
         pend  <= set_vec | (pend & ~clr_vec);
         if (we && addr == A_MASK) mask <= wr_data;
         if (we && addr == A_MODE) mode <= wr_data;
      end
   end

   assign hw_int  = pend & mask;
   assign irq_out = |hw_int;

   // Walk from the top down so the lowest-numbered active line wins.
   always_comb begin
      id = 32'hFFFF_FFFF;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (hw_int[i]) id = 32'(i);
      end
   end

   always_comb begin
      dout = '0;
      case (addr)
         A_PEND:  dout = {{(32-N_SRC){1'b0}}, pend};
         A_MASK:  dout = {{(32-N_SRC){1'b0}}, mask};
         A_MODE:  dout = {{(32-N_SRC){1'b0}}, mode};
         A_ID:    dout = id;
         default: dout = '0;
      endcase
   end

endmodule
